// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store memory stage between execute and writeback
//
// Purpose: accepts one op per cycle from execute. Non-memory ops pass straight
// to writeback. Loads/stores are checked for illegal width codes and
// misalignment, then issued as a single outstanding request on the dmem
// req/gnt/rvalid bus. Load data is lane-aligned and extended before writeback.
//
// Optional build macro: LSU_TIMEOUT_EN enables a WAIT-state watchdog that
// raises an access fault after TIMEOUT_CYCLES cycles without a response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ex_*                          op from execute (valid/ready handshake)
//   flush_i                       kills the current or incoming op
//   dmem_*                        data-memory request/response bus
//   wb_valid_o/rd/we/data         one-cycle writeback result
//   exc_valid_o/cause/tval        one-cycle exception report
module lsu_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] ex_alu_res_i,
  input  logic [DATA_WIDTH-1:0] ex_store_data_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_is_store_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_rd_we_i,
  input  logic                  flush_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_err_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_we_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  exc_valid_o,
  output logic [3:0]            exc_cause_o,
  output logic [DATA_WIDTH-1:0] exc_tval_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [4:0]            r_rd;
  logic                  r_rd_we;

  logic                  r_wb_valid;
  logic [4:0]            r_wb_rd;
  logic                  r_wb_we;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_exc_valid;
  logic [3:0]            r_exc_cause;
  logic [DATA_WIDTH-1:0] r_exc_tval;

  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_f3_illegal;
  logic                  w_misaligned;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_timeout;

  // Decode of the op presented by execute. Load wins when both load and
  // store are flagged.
  always_comb begin
    w_lane   = ex_alu_res_i[1:0];
    w_is_mem = ex_is_load_i | ex_is_store_i;
    w_accept = (r_state == S_IDLE) & ex_valid_i & ~flush_i;

    if (ex_is_load_i)
      w_f3_illegal = (ex_funct3_i == 3'b011) | (ex_funct3_i[2:1] == 2'b11);
    else
      w_f3_illegal = (ex_funct3_i > 3'b010);

    case (ex_funct3_i[1:0])
      2'b01:   w_misaligned = ex_alu_res_i[0];
      2'b10:   w_misaligned = |ex_alu_res_i[1:0];
      default: w_misaligned = 1'b0;
    endcase

    w_be    = 4'b1111;
    w_wdata = '0;
    if (!ex_is_load_i) begin
      case (ex_funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{ex_store_data_i[7:0]}};
        end
        2'b01: begin
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ex_store_data_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_store_data_i;
        end
      endcase
    end
  end

  // Load extraction from the response word using the latched lane.
  always_comb begin
    w_byte = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    w_half = dmem_rdata_i[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts WAIT cycles without a response; cleared in every other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_tmo_cnt <= '0;
    end else if (!dmem_rvalid_i) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) & ~dmem_rvalid_i &
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
  // Keeps the watchdog limit referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_limit_unused
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_is_load   <= 1'b0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_rd_we     <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= '0;
      r_exc_tval  <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= ex_rd_i;
              r_wb_we    <= ex_rd_we_i;
              r_wb_data  <= ex_alu_res_i;
            end else if (w_f3_illegal) begin
              r_exc_valid <= 1'b1;
              r_exc_cause <= 4'd2;
              r_exc_tval  <= ex_alu_res_i;
            end else if (w_misaligned) begin
              r_exc_valid <= 1'b1;
              r_exc_cause <= ex_is_load_i ? 4'd4 : 4'd6;
              r_exc_tval  <= ex_alu_res_i;
            end else begin
              r_addr    <= ex_alu_res_i;
              r_wdata   <= w_wdata;
              r_be      <= w_be;
              r_is_load <= ex_is_load_i;
              r_funct3  <= ex_funct3_i;
              r_rd      <= ex_rd_i;
              r_rd_we   <= ex_rd_we_i;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A granted request must still see its response, even if flushed.
          if (flush_i)
            r_state <= dmem_gnt_i ? S_DRAIN : S_IDLE;
          else if (dmem_gnt_i)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            r_state <= S_IDLE;
            // A flush arriving with the response just consumes it silently.
            if (!flush_i) begin
              if (dmem_err_i) begin
                r_exc_valid <= 1'b1;
                r_exc_cause <= r_is_load ? 4'd5 : 4'd7;
                r_exc_tval  <= r_addr;
              end else begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_we    <= r_is_load & r_rd_we;
                r_wb_data  <= r_is_load ? w_load_data : '0;
              end
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end else if (w_timeout) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= r_is_load ? 4'd5 : 4'd7;
            r_exc_tval  <= r_addr;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dmem_rvalid_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready_o   = (r_state == S_IDLE);
  assign dmem_req_o   = (r_state == S_REQ);
  assign dmem_we_o    = (r_state == S_REQ) & ~r_is_load;
  assign dmem_addr_o  = {r_addr[DATA_WIDTH-1:2], 2'b00};
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;
  assign wb_valid_o   = r_wb_valid;
  assign wb_rd_o      = r_wb_rd;
  assign wb_we_o      = r_wb_we;
  assign wb_data_o    = r_wb_data;
  assign exc_valid_o  = r_exc_valid;
  assign exc_cause_o  = r_exc_cause;
  assign exc_tval_o   = r_exc_tval;

endmodule
